// File: rtl/control_fsm_pkg.sv
// Shared state codes and opcode constants for the sequencer and the signal-control unit.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_RESET         = 4'd0,
    S_FETCH         = 4'd1,
    S_WAIT_ROM      = 4'd2,
    S_DECODE        = 4'd3,
    S_ULA_OP        = 4'd4,
    S_STORE_ULA_RES = 4'd5,
    S_STORE_REGA    = 4'd6,
    S_HALT          = 4'd7,
    S_IDLE          = 4'd8
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/control_fsm_ir.sv
// Instruction register: captures the ROM word into opcode/operand on load.
module control_ir (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] instr,
  output logic [3:0] opcode,
  output logic [3:0] operand
);

  logic [3:0] r_opcode;
  logic [3:0] r_operand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= '0;
      r_operand <= '0;
    end else if (load) begin
      r_opcode  <= instr[7:4];
      r_operand <= instr[3:0];
    end
  end

  assign opcode  = r_opcode;
  assign operand = r_operand;

endmodule

// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer with retired-instruction counter and halt.
// Optional CTRL_SINGLE_STEP_EN adds the step port and parks in S_IDLE between instructions.
//
// state           | meaning
// S_RESET         | post-reset, moves to fetch
// S_FETCH         | ROM read issued, pc increments once
// S_WAIT_ROM      | wait for rom_valid, capture instruction
// S_DECODE        | dispatch on latched opcode
// S_ULA_OP        | ULA computes
// S_STORE_ULA_RES | ULA result stored
// S_STORE_REGA    | register A written, instruction retires
// S_HALT          | absorbing until reset
// S_IDLE          | single-step park, waits for step
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int         COUNT_W    = 16,
  parameter logic [3:0] HLT_OPCODE = OP_HLT,
  parameter logic [3:0] NOP_OPCODE = OP_NOP
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [7:0]         instr,
  input  logic               rom_valid,
  output logic [3:0]         state,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

`ifdef CTRL_SINGLE_STEP_EN
  localparam state_e NEXT_FETCH = S_IDLE;
`else
  localparam state_e NEXT_FETCH = S_FETCH;
`endif

  state_e             r_state;
  state_e             w_next;
  logic               w_retire;
  logic               w_ir_load;
  logic               r_halted;
  logic [COUNT_W-1:0] r_count;

  assign w_ir_load = (r_state == S_WAIT_ROM) && rom_valid;

  control_ir u_ir (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_ir_load),
    .instr   (instr),
    .opcode  (opcode),
    .operand (operand)
  );

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    w_next = S_WAIT_ROM;
      S_WAIT_ROM: if (rom_valid) w_next = S_DECODE;
      S_DECODE: begin
        w_retire = (opcode == HLT_OPCODE) || (opcode == NOP_OPCODE);
        if (opcode == HLT_OPCODE)      w_next = S_HALT;
        else if (opcode == NOP_OPCODE) w_next = NEXT_FETCH;
        else                           w_next = S_ULA_OP;
      end
      S_ULA_OP:        w_next = S_STORE_ULA_RES;
      S_STORE_ULA_RES: w_next = S_STORE_REGA;
      S_STORE_REGA: begin
        w_next   = NEXT_FETCH;
        w_retire = 1'b1;
      end
      S_HALT: w_next = S_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      S_IDLE: if (step) w_next = S_FETCH;
`endif
      // Illegal codes, and S_IDLE when single-step is compiled out, recover via reset state.
      default: w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RESET;
      r_halted <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == S_HALT);
      if (w_retire) r_count <= r_count + COUNT_W'(1);
    end
  end

  assign state       = r_state;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm against a per-instruction timeline model.
module tb_control_fsm;

  typedef struct {
    logic [3:0] st;
    logic [3:0] op;
    logic [3:0] od;
    int         cnt;
    bit         cap;
    logic [7:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_valid = 1'b0;
  logic [7:0]  instr = 8'h00;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif
  logic [3:0]  state, opcode, operand;
  logic        halted;
  logic [15:0] instr_count;
  logic [3:0]  state_b, opcode_b, operand_b;
  logic        halted_b;
  logic [3:0]  count4;

  int vectors = 0;
  int miscompares = 0;

  ent_t        tl[$];
  logic [7:0]  prog_ins[$];
  int          prog_w[$];
  logic [3:0]  rec_st[$];
  logic [3:0]  rec_op[$];
  logic [3:0]  rec_od[$];
  int          rec_cnt[$];
  logic [3:0]  m_op, m_od;
  int          m_cnt;

  control_fsm #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .instr(instr), .rom_valid(rom_valid), .state(state), .opcode(opcode),
    .operand(operand), .halted(halted), .instr_count(instr_count)
  );

  control_fsm #(.COUNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .instr(instr), .rom_valid(rom_valid), .state(state_b), .opcode(opcode_b),
    .operand(operand_b), .halted(halted_b), .instr_count(count4)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [3:0] st, input bit cap, input logic [7:0] ins);
    ent_t e;
    e.st = st; e.op = m_op; e.od = m_od; e.cnt = m_cnt; e.cap = cap; e.ins = ins;
    tl.push_back(e);
  endtask

  // Expected per-cycle timeline derived from the instruction list and ROM wait counts.
  task automatic build(input int halt_tail);
    bit stopped = 0;
    tl.delete();
    m_op = 4'h0; m_od = 4'h0; m_cnt = 0;
    push(4'd0, 0, 8'h00);
    for (int i = 0; i < prog_ins.size() && !stopped; i++) begin
`ifdef CTRL_SINGLE_STEP_EN
      if (i > 0) push(4'd8, 0, 8'h00);
`endif
      push(4'd1, 0, 8'h00);
      for (int w = 0; w < prog_w[i]; w++) push(4'd2, 0, 8'h00);
      push(4'd2, 1, prog_ins[i]);
      m_op = prog_ins[i][7:4];
      m_od = prog_ins[i][3:0];
      push(4'd3, 0, 8'h00);
      if (m_op == 4'hF) begin
        m_cnt++;
        for (int h = 0; h < halt_tail; h++) push(4'd7, 0, 8'h00);
        stopped = 1;
      end else if (m_op == 4'hE) begin
        m_cnt++;
      end else begin
        push(4'd4, 0, 8'h00);
        push(4'd5, 0, 8'h00);
        push(4'd6, 0, 8'h00);
        m_cnt++;
      end
    end
    if (!stopped) begin
`ifdef CTRL_SINGLE_STEP_EN
      push(4'd8, 0, 8'h00);
`endif
      push(4'd1, 0, 8'h00);
      for (int t = 0; t < 3; t++) push(4'd2, 0, 8'h00);
    end
  endtask

  task automatic check_ent(input int idx, input ent_t e);
    vectors++;
    if (state !== e.st || opcode !== e.op || operand !== e.od || halted !== (e.st == 4'd7) ||
        instr_count !== e.cnt[15:0] || count4 !== e.cnt[3:0]) begin
      miscompares++;
      $display("FAIL cycle%0d: got state=%0d op=%h od=%h halted=%b cnt=%0d cnt4=%0d; want state=%0d op=%h od=%h halted=%b cnt=%0d cnt4=%0d",
               idx, state, opcode, operand, halted, instr_count, count4,
               e.st, e.op, e.od, (e.st == 4'd7), e.cnt[15:0], e.cnt[3:0]);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // noise: 0 none, 1 always high, 2 random -- rom_valid outside capture-eligible cycles.
  task automatic run_prog(input int noise, input bit abort_ula, input int halt_tail);
    ent_t e;
    build(halt_tail);
    rec_st.delete(); rec_op.delete(); rec_od.delete(); rec_cnt.delete();
    rst_n = 1'b0;
    rom_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int idx = 0; idx < tl.size(); idx++) begin
      e = tl[idx];
      if (e.cap) begin
        rom_valid = 1'b1;
        instr = e.ins;
      end else begin
        rom_valid = (e.st == 4'd2) ? 1'b0 :
                    (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom) : 1'b0;
        instr = 8'($urandom);
      end
      @(negedge clk);
      rec_st.push_back(state); rec_op.push_back(opcode);
      rec_od.push_back(operand); rec_cnt.push_back(int'(instr_count));
      check_ent(idx, e);
      if (abort_ula && e.st == 4'd5) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", int'(state), 0);
        chk("abort_opcode", int'(opcode), 0);
        chk("abort_operand", int'(operand), 0);
        chk("abort_halted", int'(halted), 0);
        chk("abort_count", int'(instr_count), 0);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first3, n2, f0, f1, n;
    logic [3:0] op;

    // Directed: single ULA instruction, zero ROM wait.
    prog_ins = '{8'h23}; prog_w = '{0};
    run_prog(0, 0, 0);
`ifdef CTRL_SINGLE_STEP_EN
    chk("seq_last", int'(rec_st[7]), 8);
`else
    chk("seq_last", int'(rec_st[7]), 1);
`endif
    for (int i = 0; i < 7; i++) chk("seq_state", int'(rec_st[i]), i);
    chk("ula_opcode", int'(rec_op[7]), 2);
    chk("ula_operand", int'(rec_od[7]), 3);
    chk("ula_count", rec_cnt[7], 1);

    // Directed: 4 extra ROM waits with rom_valid pulsed outside WAIT_ROM.
    prog_ins = '{8'h5A}; prog_w = '{4};
    run_prog(1, 0, 0);
    first3 = -1; n2 = 0;
    for (int i = 0; i < rec_st.size(); i++) if (first3 < 0 && rec_st[i] == 4'd3) first3 = i;
    for (int i = 0; i < first3; i++) if (rec_st[i] == 4'd2) n2++;
    chk("wait_cycles", n2, 5);
    chk("wait_opcode", int'(rec_op[first3]), 5);
    chk("wait_operand", int'(rec_od[first3]), 10);
    chk("fetch_opcode_before", int'(rec_op[first3-1]), 0);

    // Directed: NOP, ULA, HLT, then 20 halted cycles under rom_valid noise.
    prog_ins = '{8'hE0, 8'h15, 8'hF0}; prog_w = '{0, 0, 0};
    run_prog(1, 0, 20);
    f0 = -1; f1 = -1;
    for (int i = 0; i < rec_st.size(); i++)
      if (rec_st[i] == 4'd1) begin
        if (f0 < 0) f0 = i;
        else if (f1 < 0) f1 = i;
      end
`ifdef CTRL_SINGLE_STEP_EN
    chk("nop_cycles", f1 - f0, 4);
`else
    chk("nop_cycles", f1 - f0, 3);
`endif
    chk("halt_state", int'(state), 7);
    chk("halt_flag", int'(halted), 1);
    chk("halt_count", int'(instr_count), 3);

    // Directed: reset during S_STORE_ULA_RES.
    prog_ins = '{8'h23}; prog_w = '{1};
    run_prog(2, 1, 0);

    // Directed: 17 NOPs wrap the 4-bit counter instance.
    prog_ins.delete(); prog_w.delete();
    for (int i = 0; i < 17; i++) begin prog_ins.push_back(8'hE7); prog_w.push_back(0); end
    run_prog(2, 0, 0);
    chk("wrap_count4", int'(count4), 1);
    chk("wrap_count16", int'(instr_count), 17);

    // Randomized programs.
    for (int p = 0; p < 8; p++) begin
      prog_ins.delete(); prog_w.delete();
      n = $urandom_range(10, 40);
      for (int i = 0; i < n; i++) begin
        op = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 13));
        if (i == n - 1 && p[0]) op = 4'hF;
        prog_ins.push_back({op, 4'($urandom)});
        prog_w.push_back($urandom_range(0, 3));
      end
      run_prog(2, 0, 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Main sequencer of the processor datapath: walks the fetch/decode/execute cycle, latches the instruction word returned by the ROM, and drives the `state` and `opcode` buses consumed by the signal-control unit. That unit turns them into `rom_read`, `pc_increment`, `gp_read`/`gp_write` and the ULA strobes. control_fsm also counts retired instructions and stops the core on a halt opcode.

## Interface
- `COUNT_W`, 16: width of retired-instruction counter
- `HLT_OPCODE`, 4'hF: opcode that halts the core
- `NOP_OPCODE`, 4'hE: opcode that retires without a ULA operation

- `clk`  in  1  single system clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `instr`  in  8  instruction word from ROM; `[7:4]` opcode, `[3:0]` operand
- `rom_valid`  in  1  ROM data valid, sampled only in `S_WAIT_ROM`
- `step`  in  1  single-step advance; present only with `CTRL_SINGLE_STEP_EN`
- `state`  out  4  current state code, to signal-control unit
- `opcode`  out  4  latched opcode
- `operand`  out  4  latched operand
- `halted`  out  1  high while in `S_HALT`
- `instr_count`  out  `COUNT_W`  retired-instruction count

## Operation
- State codes:
  - `S_RESET`=0, `S_FETCH`=1, `S_WAIT_ROM`=2, `S_DECODE`=3
  - `S_ULA_OP`=4, `S_STORE_ULA_RES`=5, `S_STORE_REGA`=6
  - `S_HALT`=7, `S_IDLE`=8
  - Codes 9–15 are illegal and go to `S_RESET` on the next clock.
- Transitions:
  - `S_RESET`→`S_FETCH`
  - `S_FETCH`→`S_WAIT_ROM` unconditionally; exactly one cycle, so `pc_increment` fires once per instruction.
  - `S_WAIT_ROM`: stays while `rom_valid`=0. When `rom_valid`=1, latches `instr[7:4]`→`opcode`, `instr[3:0]`→`operand`, goes to `S_DECODE`.
  - `S_DECODE`: `HLT_OPCODE`→`S_HALT`; `NOP_OPCODE`→next-fetch; any other opcode→`S_ULA_OP`.
  - `S_ULA_OP`→`S_STORE_ULA_RES`→`S_STORE_REGA`→next-fetch
  - `S_HALT` is absorbing; only `rst_n` leaves it.
- Next-fetch is `S_FETCH`, or `S_IDLE` when single-step is enabled.
- `opcode`/`operand` are stable from `S_DECODE` until the next `rom_valid` capture. `rom_valid` outside `S_WAIT_ROM` is ignored.
- `instr_count` increments by 1 on every retirement: leaving `S_STORE_REGA`, leaving `S_DECODE` on NOP, or entering `S_HALT`. It wraps from all-ones to 0 with no flag.
- `halted` = (`state`==`S_HALT`), registered with the state.

## Timing
- Every output is registered.
- Reset values: `state`=`S_RESET`, `opcode`=0, `operand`=0, `halted`=0, `instr_count`=0.
- Asserting `rst_n` mid-instruction takes effect immediately and aborts the instruction, which is not counted. Deassertion is synchronised by the core's reset tree; the first edge after release moves to `S_FETCH`.
- Latencies:
  - ULA instruction: 6 cycles with zero ROM wait (`FETCH`, `WAIT_ROM`, `DECODE`, `ULA_OP`, `STORE_ULA_RES`, `STORE_REGA`) plus one cycle per extra ROM wait cycle.
  - NOP: 3 cycles.
  - HLT: `halted` rises 3 cycles after `S_FETCH`.
- `instr_count` updates on the same edge as the retiring state transition.

## Configuration
- `CTRL_SINGLE_STEP_EN` defined:
  - The `step` port exists and next-fetch is `S_IDLE`.
  - `S_IDLE` stays while `step`=0 and goes to `S_FETCH` on the first cycle `step`=1. `step` held high steps every instruction.
  - `S_RESET` still goes directly to `S_FETCH`.
- Not defined: no `step` port, `S_IDLE` is never entered, and code 8 is treated as illegal.

## Structure
- Shared header/package: the `S_*` state codes, which the signal-control unit uses too. It also holds opcode constants: the ULA operation codes plus the `HLT`/`NOP` defaults.
- One sub-module, `control_ir`: the instruction register. Its inputs are `clk`, `rst_n`, a load enable (`S_WAIT_ROM` && `rom_valid`) and `instr`; its outputs are `opcode`/`operand`. The FSM and counter stay in control_fsm.

## Test plan
- Reset, then ROM returns 8'h23 with `rom_valid` on the first `S_WAIT_ROM` cycle → states 0,1,2,3,4,5,6,1; `opcode`=2, `operand`=3; `instr_count`=1 after `S_STORE_REGA`.
- `rom_valid` held low 4 cycles in `S_WAIT_ROM`, pulsed during `S_FETCH` → stays in state 2 for 5 cycles; the early pulse is ignored; capture happens on the late pulse only.
- Sequence 8'hE0, 8'h15, 8'hF0 → NOP retires in 3 cycles; `halted`=1 and `instr_count`=3; `state` stays 7 for 20 further cycles regardless of `rom_valid`.
- `rst_n` low during `S_STORE_ULA_RES` → `state`=0 immediately, all outputs at reset values, count not incremented.
- `instr_count` preloaded to all-ones by forcing, then one NOP → wraps to 0.
- With `CTRL_SINGLE_STEP_EN`, `step`=0 after the first retirement → sits in state 8; a 1-cycle `step` pulse yields exactly one `S_FETCH` cycle and one instruction.
